// File: rtl/valid_ready_upsizer_if.sv
// valid_ready_upsizer_if
//   Bundles both handshakes of the width up-converter.
//   Upstream side : valid_up, data_up[width], last_up, ready_up
//   Downstream side: valid_down, data_down[width*ratio], count_down[cw],
//                    last_down, ready_down
//   Modports:
//     slave  - the up-converter (consumes beats, produces words)
//     master - the surrounding logic (produces beats, consumes words)
interface valid_ready_upsizer_if #(
    parameter int width = 4,
    parameter int ratio = 4
);
    localparam int cw = $clog2(ratio) + 1;

    logic                   valid_up;
    logic [width-1:0]       data_up;
    logic                   last_up;
    logic                   ready_up;

    logic                   valid_down;
    logic [width*ratio-1:0] data_down;
    logic [cw-1:0]          count_down;
    logic                   last_down;
    logic                   ready_down;

    modport slave (
        input  valid_up, data_up, last_up, ready_down,
        output ready_up, valid_down, data_down, count_down, last_down
    );

    modport master (
        output valid_up, data_up, last_up, ready_down,
        input  ready_up, valid_down, data_down, count_down, last_down
    );
endinterface

// File: rtl/valid_ready_upsizer.sv
// valid_ready_upsizer
//   Packs `ratio` consecutive `width`-bit beats into one width*ratio-bit word.
//   Beat 0 of a word sits in the LSBs. last_up closes a word early; unused
//   upper slots of such a partial word are zero. The packed word is held in a
//   single output register with a valid/ready handshake.
//   Ports:
//     clk  - clock, all state on rising edge
//     rst  - synchronous active-high reset
//     bus  - valid_ready_upsizer_if.slave carrying both handshakes
module valid_ready_upsizer #(
    parameter int width = 4,
    parameter int ratio = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    valid_ready_upsizer_if.slave  bus
);
    localparam int cw = $clog2(ratio) + 1;
    localparam int iw = (ratio > 1) ? $clog2(ratio) : 1;
    localparam int ww = width * ratio;

    logic [iw-1:0] idx_q,   idx_d;
    logic [ww-1:0] acc_q,   acc_d;
    logic          valid_q, valid_d;
    logic [ww-1:0] data_q,  data_d;
    logic [cw-1:0] count_q, count_d;
    logic          last_q,  last_d;

    logic [ww-1:0] merged;
    logic          ready_up;
    logic          accept;
    logic          at_end;
    logic          complete;

    // Accumulator with the incoming beat dropped into the current slot.
    generate
        for (genvar gi = 0; gi < ratio; gi++) begin : g_slot
            localparam logic [iw-1:0] SLOT = iw'(gi);
            assign merged[gi*width +: width] = (idx_q == SLOT)
                                             ? bus.data_up
                                             : acc_q[gi*width +: width];
        end
    endgenerate

    // Upstream may only move when the output register is free or draining
    // this cycle; this keeps acc/idx frozen during a downstream stall.
    assign ready_up = !valid_q || bus.ready_down;
    assign accept   = bus.valid_up && ready_up;
    assign at_end   = (idx_q == iw'(ratio - 1));
    assign complete = accept && (at_end || bus.last_up);

    always_comb begin
        idx_d   = idx_q;
        acc_d   = acc_q;
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        last_d  = last_q;

        if (accept) begin
            if (complete) begin
                idx_d = '0;
                acc_d = '0;
            end else begin
                idx_d = idx_q + iw'(1);
                acc_d = merged;
            end
        end

        // A completing beat wins over a drain, so back-to-back words
        // keep valid high with no gap.
        if (complete) begin
            valid_d = 1'b1;
            data_d  = merged;
            count_d = cw'(idx_q) + cw'(1);
            last_d  = bus.last_up;
        end else if (valid_q && bus.ready_down) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    assign bus.ready_up   = ready_up;
    assign bus.valid_down = valid_q;
    assign bus.data_down  = data_q;
    assign bus.count_down = count_q;
    assign bus.last_down  = last_q;
endmodule

// File: doc/valid_ready_upsizer.md
# valid_ready_upsizer

Width up-converter that sits directly downstream of `valid_ready_flop`. It consumes a stream of `width`-bit beats over a valid/ready handshake and packs `ratio` consecutive beats into one `width*ratio`-bit word. A `last_up` marker can close a packet early, which flushes a partial word. The packed word is presented on a registered valid/ready output towards the next stage.

## Interface
- `width`, default 4: bits per input beat.
- `ratio`, default 4: beats per output word; legal range ≥ 1.
- Derived localparam `cw` = $clog2(ratio)+1: width of the beat-count output.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_up`  in  1  input beat valid.
- `data_up`  in  `width`  input beat data.
- `last_up`  in  1  beat is final beat of packet; qualified by `valid_up`.
- `ready_up`  out  1  block can accept a beat this cycle.
- `valid_down`  out  1  output word valid (registered).
- `data_down`  out  `width*ratio`  packed word (registered).
- `count_down`  out  `cw`  number of valid beats in `data_down`, range 1..`ratio` (registered).
- `last_down`  out  1  word ends a packet (registered).
- `ready_down`  in  1  downstream accepts word.

## Operation
- Internal state:
  - slot index `idx` (0..`ratio`-1);
  - accumulator `acc` (`width*ratio` bits);
  - output register holding `data_down`, `count_down`, `last_down` and `valid_down`.
- Beat accept: `valid_up && ready_up` at a rising edge.
  - The beat is written to `acc[idx*width +: width]`; beat 0 goes in the LSBs.
- Completing beat: an accepted beat with `idx == ratio-1` or `last_up == 1`. At that edge:
  - the output register loads `{acc` with the current beat merged`}`;
  - `count_down` = `idx+1`;
  - `last_down` = `last_up`;
  - `valid_down` = 1;
  - `idx` returns to 0 and `acc` clears to 0.
- Partial words (closed by `last_up`) have unused upper slots equal to 0.
- A non-completing accepted beat increments `idx`.
- `ready_up = !valid_down || ready_down`. This is combinational from `ready_down` and has no dependency on `valid_up`, `data_up` or `last_up`.
- Output transfer: `valid_down && ready_down` at an edge. If no completing beat arrives at the same edge, `valid_down` clears to 0.
- While `valid_down && !ready_down`:
  - `data_down`, `count_down` and `last_down` are held stable;
  - `ready_up` = 0, so no beat is accepted and `acc`/`idx` are frozen.
- `ratio == 1`: every accepted beat is completing; `count_down` is always 1.

## Timing
- Reset (`rst` = 1 at an edge):
  - outputs go to `valid_down` = 0, `data_down` = 0, `count_down` = 0, `last_down` = 0;
  - internal state goes to `idx` = 0, `acc` = 0;
  - `ready_up` is therefore 1 in the cycle after reset.
- Reset mid-word: the partial word is discarded. Reset mid-hold: the held output word is dropped.
- Reset has priority over every handshake in the same cycle.
- Latency: the completing beat is accepted at edge N; `valid_down` = 1 from edge N through the following cycle. This is one register stage.
- Throughput with `ready_down` held at 1: one beat per cycle sustained, i.e. one word per `ratio` cycles with no bubbles.
- Simultaneous output transfer and completing beat at the same edge: the new word loads and `valid_down` stays 1 with no gap cycle.
- `last_up` on beat `ratio`-1 (full word): `count_down` = `ratio`, `last_down` = 1.
- `last_up` with `valid_up` = 0 is ignored.

## Test plan
All scenarios use `width` = 4, `ratio` = 4.

- **Reset:** hold `rst` = 1 for 2 cycles with random inputs → `valid_down` = 0, `data_down` = 16'h0, `count_down` = 0, `last_down` = 0; `ready_up` = 1 after release.
- **Full-rate stream:** `ready_down` = 1, beats 1..8 with `last_up` = 0 → words 16'h4321 then 16'h8765, each with `count_down` = 4 and `last_down` = 0; `valid_down` rises one edge after the 4th and 8th beats; `ready_up` stays 1 throughout.
- **Early last:** beats 4'hA, then 4'hB with `last_up` = 1 → `data_down` = 16'h00BA, `count_down` = 2, `last_down` = 1. The following beats 1..4 produce 16'h4321, which confirms `idx` and `acc` restarted from 0.
- **Backpressure:** complete word 16'h4321, then hold `ready_down` = 0 for 5 cycles while `valid_up` = 1 with data 5 → `valid_down` = 1, `data_down` stable at 16'h4321, `ready_up` = 0, no beat accepted. Raise `ready_down` → transfer occurs at that edge, `ready_up` = 1 the same cycle, and beat 5 lands in slot 0.
- **Reset mid-word:** accept beats 1 and 2, pulse `rst`, then send beats 5..8 → a single word 16'h8765 with `count_down` = 4; no trace of 1 or 2 appears.
- **Last on full slot plus back-to-back:** beats 1..4 with `last_up` on beat 4, immediately followed by beats 5..8 with `ready_down` = 1 → 16'h4321 with `last_down` = 1, then 16'h8765 with `last_down` = 0; `valid_down` is continuous across the boundary with no bubble.
